// File: rtl/timer_host_master.sv
// ---------------------------------------------------------------------------
// timer_host_master
//
// Purpose:
//   Avalon-MM host that drives an interval-timer slave on behalf of a
//   simple command interface. It performs four sequences:
//     * start    : write period low/high words, then the control word
//     * stop     : write the STOP bit to the control register
//     * service  : clear the timeout status when the timer's irq is high
//     * snapshot : latch the running counter in the slave and read it back
//
// Ports:
//   clk, reset_n        system clock; asynchronous active-low reset
//   cmd_start           pulse: latch cmd_period/cmd_continuous and start timer
//   cmd_period[31:0]    timer period, sampled on start acceptance
//   cmd_continuous      continuous-mode flag, sampled on start acceptance
//   cmd_stop            pulse: stop the timer
//   snap_req            pulse: snapshot the counter and read it back
//   busy                high while a bus sequence is in flight
//   snap_valid          one-cycle pulse, snap_value valid in that cycle
//   snap_value[31:0]    last snapshot read, {high word, low word}
//   tick_count[15:0]    number of serviced timeouts (wraps)
//   tick_pulse          one-cycle pulse per serviced timeout
//   m_address[2:0]      Avalon word address
//   m_chipselect        Avalon slave select
//   m_write_n           Avalon active-low write
//   m_writedata[15:0]   Avalon write data
//   m_readdata[15:0]    Avalon read data (registered slave, 1-cycle latency)
//   irq_in              level interrupt from the timer
//
// All outputs come straight from flops. The bus outputs for a state are
// decoded from the next state and registered together with it, so they are
// valid in the same cycle the FSM sits in that state.
// ---------------------------------------------------------------------------
module timer_host_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_stop,
  input  logic        snap_req,
  output logic        busy,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic [15:0] tick_count,
  output logic        tick_pulse,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        irq_in
);

  // Timer slave register map (word addresses)
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register bits: ITO=bit0, CONT=bit1, START=bit2, STOP=bit3
  localparam logic [15:0] CTL_START_ONESHOT = 16'h0005;
  localparam logic [15:0] CTL_START_CONT    = 16'h0007;
  localparam logic [15:0] CTL_STOP          = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    WR_STOP,
    CLR_ST,
    SNAP_W,
    SNAP_RL,
    SNAP_RH,
    SNAP_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        cont_q, cont_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic        tick_pulse_q, tick_pulse_d;
  // Set for the single IDLE cycle after CLR_ST: the slave's irq still
  // reflects the old status in that cycle, so it must not trigger a service.
  logic        irq_hold_q, irq_hold_d;
  logic        busy_q, busy_d;
  logic [2:0]  m_address_q, m_address_d;
  logic        m_chipselect_q, m_chipselect_d;
  logic        m_write_n_q, m_write_n_d;
  logic [15:0] m_writedata_q, m_writedata_d;

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    tick_count_d = tick_count_q;
    tick_pulse_d = 1'b0;
    irq_hold_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Fixed priority; requests seen outside IDLE are simply not looked at.
        if (cmd_stop) begin
          state_d = WR_STOP;
        end else if (irq_in && !irq_hold_q) begin
          state_d = CLR_ST;
        end else if (cmd_start) begin
          state_d  = WR_PL;
          period_d = cmd_period;
          cont_d   = cmd_continuous;
        end else if (snap_req) begin
          state_d = SNAP_W;
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  state_d = IDLE;
      WR_STOP: state_d = IDLE;
      CLR_ST: begin
        state_d      = IDLE;
        tick_count_d = tick_count_q + 16'd1;
        tick_pulse_d = 1'b1;
        irq_hold_d   = 1'b1;
      end
      SNAP_W:  state_d = SNAP_RL;
      SNAP_RL: state_d = SNAP_RH;
      SNAP_RH: begin
        // Read data for the SNAP_RL access arrives during this cycle.
        state_d   = SNAP_DONE;
        snap_lo_d = m_readdata;
      end
      SNAP_DONE: begin
        // Read data for the SNAP_RH access arrives during this cycle.
        state_d      = IDLE;
        snap_value_d = {m_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus decode for the state about to be entered
  // -------------------------------------------------------------------------
  always_comb begin
    m_chipselect_d = 1'b0;
    m_write_n_d    = 1'b1;
    m_address_d    = 3'd0;
    m_writedata_d  = 16'h0000;
    busy_d         = (state_d != IDLE);

    case (state_d)
      WR_PL: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_PERIODL;
        m_writedata_d  = period_d[15:0];
      end
      WR_PH: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_PERIODH;
        m_writedata_d  = period_d[31:16];
      end
      WR_CTL: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CONTROL;
        m_writedata_d  = cont_d ? CTL_START_CONT : CTL_START_ONESHOT;
      end
      WR_STOP: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_CONTROL;
        m_writedata_d  = CTL_STOP;
      end
      CLR_ST: begin
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_STATUS;
        m_writedata_d  = 16'h0000;
      end
      SNAP_W: begin
        // Any write to SNAPL makes the slave latch its counter.
        m_chipselect_d = 1'b1;
        m_write_n_d    = 1'b0;
        m_address_d    = ADDR_SNAPL;
        m_writedata_d  = 16'h0000;
      end
      SNAP_RL: begin
        m_chipselect_d = 1'b1;
        m_address_d    = ADDR_SNAPL;
      end
      SNAP_RH: begin
        m_chipselect_d = 1'b1;
        m_address_d    = ADDR_SNAPH;
      end
      default: begin
        // IDLE and SNAP_DONE leave the bus idle.
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers; reset aborts any sequence immediately.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      period_q       <= 32'd0;
      cont_q         <= 1'b0;
      snap_lo_q      <= 16'h0000;
      snap_value_q   <= 32'd0;
      snap_valid_q   <= 1'b0;
      tick_count_q   <= 16'h0000;
      tick_pulse_q   <= 1'b0;
      irq_hold_q     <= 1'b0;
      busy_q         <= 1'b0;
      m_address_q    <= 3'd0;
      m_chipselect_q <= 1'b0;
      m_write_n_q    <= 1'b1;
      m_writedata_q  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      cont_q         <= cont_d;
      snap_lo_q      <= snap_lo_d;
      snap_value_q   <= snap_value_d;
      snap_valid_q   <= snap_valid_d;
      tick_count_q   <= tick_count_d;
      tick_pulse_q   <= tick_pulse_d;
      irq_hold_q     <= irq_hold_d;
      busy_q         <= busy_d;
      m_address_q    <= m_address_d;
      m_chipselect_q <= m_chipselect_d;
      m_write_n_q    <= m_write_n_d;
      m_writedata_q  <= m_writedata_d;
    end
  end

  assign busy         = busy_q;
  assign snap_valid   = snap_valid_q;
  assign snap_value   = snap_value_q;
  assign tick_count   = tick_count_q;
  assign tick_pulse   = tick_pulse_q;
  assign m_address    = m_address_q;
  assign m_chipselect = m_chipselect_q;
  assign m_write_n    = m_write_n_q;
  assign m_writedata  = m_writedata_q;

endmodule

// File: doc/timer_host_master.md
TIMER_HOST_MASTER -- requirements
Module: timer_host_master

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 cmd_start  in  1  one-cycle pulse: program the timer period and start it.
REQ-004 cmd_period  in  32  period value, sampled when cmd_start is accepted.
REQ-005 cmd_continuous  in  1  continuous-mode flag, sampled with cmd_start.
REQ-006 cmd_stop  in  1  one-cycle pulse: stop the timer.
REQ-007 snap_req  in  1  one-cycle pulse: capture the counter and read it back.
REQ-008 busy  out  1  high whenever the FSM is not in IDLE.
REQ-009 snap_valid  out  1  one-cycle pulse; snap_value is valid in that cycle.
REQ-010 snap_value  out  32  last snapshot read, {high word, low word}.
REQ-011 tick_count  out  16  count of serviced timeouts.
REQ-012 tick_pulse  out  1  one-cycle pulse per serviced timeout.
REQ-013 m_address  out  3  Avalon-MM word address to the timer slave.
REQ-014 m_chipselect  out  1  slave select.
REQ-015 m_write_n  out  1  active-low write.
REQ-016 m_writedata  out  16  write data.
REQ-017 m_readdata  in  16  slave read data, registered, 1-cycle latency, no waitrequest.
REQ-018 irq_in  in  1  level interrupt from the timer.

Function
REQ-019 The FSM SHALL have these states: IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, CLR_ST, SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE.
REQ-020 Each write state SHALL drive one bus cycle: chipselect=1, write_n=0.
REQ-021 Each read state SHALL drive chipselect=1, write_n=1.
REQ-022 In IDLE and SNAP_DONE the bus SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-023 IDLE priority, evaluated each cycle: cmd_stop > irq_in > cmd_start > snap_req.
REQ-024 Pulses that arrive while busy=1 SHALL be ignored (dropped, not queued).
REQ-025 Start sequence: IDLE -> WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTL (addr 1) -> IDLE.
REQ-026 WR_CTL writedata SHALL be 0x0005 (ITO|START), or 0x0007 when continuous.
REQ-027 cmd_period and cmd_continuous SHALL be latched on acceptance; later input changes SHALL not affect the sequence in flight.
REQ-028 Stop: IDLE -> WR_STOP (addr 1, data 0x0008) -> IDLE.
REQ-029 Service: IDLE with irq_in=1 -> CLR_ST (addr 0, data 0x0000) -> IDLE.
REQ-030 Leaving CLR_ST SHALL increment tick_count by 1 (0xFFFF wraps to 0x0000) and assert tick_pulse for that one cycle.
REQ-031 The cycle after CLR_ST SHALL be spent in IDLE without servicing irq, so the slave's cleared irq is resampled before any new service decision.
REQ-032 Snapshot: IDLE -> SNAP_W (addr 4 write, data 0) -> SNAP_RL (addr 4 read) -> SNAP_RH (addr 5 read) -> SNAP_DONE -> IDLE.
REQ-033 The low word SHALL be sampled from m_readdata in SNAP_RH.
REQ-034 The high word SHALL be sampled from m_readdata in SNAP_DONE.
REQ-035 snap_value SHALL update and snap_valid SHALL pulse in the cycle after SNAP_DONE.
REQ-036 Start-to-idle latency SHALL be 4 cycles including acceptance; snapshot latency (request to snap_valid) SHALL be 5 cycles.
REQ-037 An irq arriving during a start or snapshot sequence SHALL remain pending (level) and be serviced on return to IDLE.
REQ-038 All bus outputs and user outputs SHALL be registered (no combinational input-to-output paths).

Reset
REQ-039 While reset_n=0: state=IDLE; busy=0, snap_valid=0, tick_pulse=0, snap_value=0, tick_count=0.
REQ-040 While reset_n=0: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0; latched command=0.
REQ-041 Reset asserted mid-sequence SHALL abort it immediately with no further bus cycles; the partially programmed timer is not restored.

Verification
REQ-042 cmd_start, period=0x0001_86A0, continuous=1 -> writes addr2=0x86A0, addr3=0x0001, addr1=0x0007 on consecutive cycles; busy high for 3 cycles.
REQ-043 irq_in held high until the addr0 write -> exactly one addr0 write of 0x0000; tick_count 0->1; one tick_pulse; no second service.
REQ-044 snap_req with slave model snapshot 0x0002_1234 -> snap_value=0x00021234 and snap_valid exactly 5 cycles after the request.
REQ-045 cmd_stop, irq_in and cmd_start all asserted in the same IDLE cycle -> addr1=0x0008 written first, then addr0 clear; cmd_start dropped.
REQ-046 tick_count preloaded to 0xFFFF via 65535 services (or a force), then one more irq -> tick_count=0x0000 and tick_pulse asserted.
REQ-047 reset_n pulsed low during WR_PH -> no WR_CTL cycle occurs and all outputs return to reset values asynchronously.
